ysyx_25030093_ifu: RTL and testbench
====================================

# ysyx_25030093_ifu

Instruction fetch unit for the multi-cycle ysyx_25030093 core. It is the consumer of the PC stage's `pc`/`out_valid_pc` handshake. It turns each valid PC into an AXI4-Lite read on the instruction bus, then hands the returned word to the decode stage with a one-cycle valid pulse. After reset it self-starts the first fetch from the reset vector, because the PC stage only signals valid after a writeback.

## Interface
Parameters:
- `RESET_PC`, default 32'h30000000: address of the self-started first fetch after reset.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `in_valid_pc`  in  1: one-cycle pulse; `pc` is valid and must be fetched.
- `pc`  in  32: fetch address, sampled when `in_valid_pc` is accepted.
- `araddr`  out  32: AXI read address.
- `arvalid`  out  1: AXI read-address valid.
- `arready`  in  1: AXI read-address ready.
- `rdata`  in  32: AXI read data.
- `rresp`  in  2: AXI read response; 2'b00 = OKAY.
- `rvalid`  in  1: AXI read-data valid.
- `rready`  out  1: AXI read-data ready.
- `inst`  out  32: fetched instruction; held until the next completion.
- `inst_pc`  out  32: address `inst` was fetched from.
- `out_valid_IFU`  out  1: one-cycle pulse; `inst`/`inst_pc`/`fetch_err` are valid.
- `fetch_err`  out  1: the completing fetch failed. Set on a non-OKAY `rresp`, or on a misaligned address when the alignment check is compiled in.
- `busy`  out  1: high in every state other than IDLE.

## Operation
FSM with states IDLE, ADDR and DATA.
- Reset (async) values:
  - state = ADDR, `araddr` = `RESET_PC`, `arvalid` = 1.
  - `rready` = 0, `inst` = 0, `inst_pc` = 0, `out_valid_IFU` = 0, `fetch_err` = 0, `busy` = 1.
- IDLE, `in_valid_pc` = 1: latch `araddr` <= `pc` and go to ADDR. `in_valid_pc` is ignored in ADDR and DATA; upstream guarantees it only arrives in IDLE.
- ADDR: `arvalid` = 1, `araddr` stable. Stay in ADDR until `arvalid & arready`, then go to DATA.
- DATA: `rready` = 1. On `rvalid`:
  - register `inst` <= `rdata`, `inst_pc` <= `araddr`, `fetch_err` <= (`rresp` != 0);
  - pulse `out_valid_IFU`;
  - go to IDLE.
- `rvalid` outside DATA is never consumed, since `rready` = 0 there.
- `inst` is written with `rdata` even on an error response. Decode must qualify it with `fetch_err`.
- `out_valid_IFU` is high for exactly one cycle per completed fetch. It never asserts twice without an intervening fetch.
- Reset mid-transaction: the outstanding AXI read is abandoned (the slave shares the reset) and the FSM restarts the `RESET_PC` fetch.

## Timing
- Cycle 0 (IDLE): `in_valid_pc` is sampled at edge 0.
- Cycle 1: `arvalid` is high. If `arready` = 1, the AR handshake completes at edge 1.
- Cycle 2: `rready` is high. If `rvalid` = 1, the data is captured at edge 2.
- Cycle 3: `out_valid_IFU` = 1 and state is IDLE. Minimum latency is 3 cycles from pulse to valid.
- Each slave stall cycle (in either channel) adds one cycle.
- `busy` falls in the same cycle `out_valid_IFU` rises.
- A new `in_valid_pc` is accepted in that same cycle 3.
- All outputs are registered; there is no combinational path from AXI inputs to outputs.

## Configuration
Macro: `YSYX_25030093_IFU_MISALIGN_CHK_EN`.
- Defined:
  - An accepted `pc` with `pc[1:0]` != 0 issues no AXI read.
  - The next cycle pulses `out_valid_IFU` with `fetch_err` = 1, `inst` = 0 and `inst_pc` = `pc`, and the FSM returns to IDLE.
  - This also applies to the reset fetch.
- Undefined: `araddr[1:0]` is forced to 2'b00, and `inst_pc` keeps the full unmodified `pc`.

## Structure
- Shared package `ysyx_25030093_pkg` holds:
  - the IFU state enum (IDLE/ADDR/DATA);
  - the response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - the default reset vector 32'h30000000.
- No sub-module: the FSM and registers form a single module.

## Test plan
- Reset released with `arready` = `rvalid` = 1 and `rdata` = 32'h00000413: expect `araddr` = 32'h30000000, then an `out_valid_IFU` pulse with `inst` = 32'h00000413 and `inst_pc` = 32'h30000000.
- `in_valid_pc` with `pc` = 32'h30000104, with `arready` delayed 2 cycles and `rvalid` delayed 3: expect `araddr` held stable, valid at cycle 3+5 = 8, and exactly one pulse.
- `rresp` = 2'b10 on a fetch of 32'h30000010: expect `fetch_err` = 1 with the pulse, and `fetch_err` = 0 on the next OKAY fetch.
- `in_valid_pc` pulsed while in DATA: expect it ignored, `araddr` unchanged, and a single completion.
- `reset` driven low while in DATA, then released: expect all outputs at reset values and a new fetch of 32'h30000000 with no stale `out_valid_IFU`.
- With the macro defined, `pc` = 32'h30000002: expect no `arvalid`, and one cycle later `out_valid_IFU` = 1, `fetch_err` = 1, `inst` = 0. With the macro undefined, expect `araddr` = 32'h30000000.

Source files
------------

// File: rtl/ysyx_25030093_pkg.sv
// Shared definitions for the ysyx_25030093 core.
//   ifu_state_e      : instruction fetch FSM states (IDLE / ADDR / DATA)
//   RESP_*           : AXI4-Lite response codes
//   DEFAULT_RESET_PC : address of the first instruction after reset
//   resp_is_err()    : any response other than OKAY is a failed access
//   word_aligned()   : true when the two address LSBs are zero
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_ADDR = 2'd1,
    IFU_DATA = 2'd2
  } ifu_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit of the multi-cycle ysyx_25030093 core.
// Takes a PC from the PC stage, performs one AXI4-Lite read per PC and
// hands the returned word to decode with a one-cycle valid pulse. After
// reset it fetches RESET_PC on its own.
//
// Ports:
//   clock, reset (async, active low)
//   in_valid_pc, pc                    : fetch request pulse from the PC stage
//   araddr, arvalid, arready           : AXI read-address channel
//   rdata, rresp, rvalid, rready       : AXI read-data channel
//   inst, inst_pc, fetch_err           : last completed fetch (held)
//   out_valid_IFU                      : one-cycle completion pulse
//   busy                               : high whenever the FSM is not IDLE
//   state_dbg                          : current FSM state, for observation
//
// Build option: YSYX_25030093_IFU_MISALIGN_CHK_EN
//   defined   : a misaligned PC issues no read and completes with fetch_err
//   undefined : araddr[1:0] is forced to zero; inst_pc keeps the full PC
//
// Handshake: a transfer on either AXI channel happens on a rising edge where
// both valid and ready are high. arvalid stays high with araddr stable until
// arready is seen; rready is high for the whole DATA state, and the read
// data is taken on the first edge where rvalid is also high.
module ysyx_25030093_ifu
  import ysyx_25030093_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid_pc,
  input  logic [31:0] pc,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        out_valid_IFU,
  output logic        fetch_err,
  output logic        busy,
  output ifu_state_e  state_dbg
);

  ifu_state_e  state_q;
  ifu_state_e  state_d;
  logic [31:0] fetch_pc_q;   // full, unmodified fetch address
  logic        pc_bad;       // incoming pc is misaligned and must not be read
  logic        addr_bad;     // held fetch address is misaligned
  logic        accept;
  logic        data_done;
  logic        err_done;

`ifdef YSYX_25030093_IFU_MISALIGN_CHK_EN
  assign pc_bad   = !word_aligned(pc[1:0]);
  assign addr_bad = !word_aligned(fetch_pc_q[1:0]);
  assign araddr   = fetch_pc_q;
`else
  assign pc_bad   = 1'b0;
  assign addr_bad = 1'b0;
  assign araddr   = {fetch_pc_q[31:2], 2'b00};
`endif

  assign accept    = (state_q == IFU_IDLE) && in_valid_pc;
  assign data_done = (state_q == IFU_DATA) && rvalid;
  // A misaligned request either arrives in IDLE, or is the reset vector
  // sitting in ADDR straight out of reset. Both complete without a read.
  assign err_done  = (accept && pc_bad) || ((state_q == IFU_ADDR) && addr_bad);

  // Outputs below decode only registered state, so no AXI input reaches
  // an output combinationally.
  assign arvalid   = (state_q == IFU_ADDR) && !addr_bad;
  assign rready    = (state_q == IFU_DATA);
  assign busy      = (state_q != IFU_IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE: begin
        if (accept && !pc_bad) state_d = IFU_ADDR;
      end
      IFU_ADDR: begin
        if (addr_bad)     state_d = IFU_IDLE;
        else if (arready) state_d = IFU_DATA;
      end
      IFU_DATA: begin
        if (rvalid) state_d = IFU_IDLE;
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IFU_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inst          <= 32'h0;
      inst_pc       <= 32'h0;
      out_valid_IFU <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      out_valid_IFU <= data_done || err_done;
      if (accept) fetch_pc_q <= pc;
      if (data_done) begin
        // Data is kept even on an error response; decode qualifies it.
        inst      <= rdata;
        inst_pc   <= fetch_pc_q;
        fetch_err <= resp_is_err(rresp);
      end else if (err_done) begin
        inst      <= 32'h0;
        inst_pc   <= accept ? pc : fetch_pc_q;
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Self-checking bench for ysyx_25030093_ifu. The bench plays the PC stage
// and an AXI4-Lite slave with per-fetch channel delays; expected results
// come from the fetch rules (address, data, response, latency 3 + stalls).
module tb_ysyx_25030093_ifu;
  import ysyx_25030093_pkg::*;

  localparam int W = 65;            // {fetch_err, inst, inst_pc}
  localparam int BUDGET = 40;
  localparam logic [31:0] RST_PC = 32'h3000_0000;
`ifdef YSYX_25030093_IFU_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        in_valid_pc;
  logic [31:0] pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        out_valid_IFU;
  logic        fetch_err;
  logic        busy;
  ifu_state_e  state_dbg;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  ysyx_25030093_ifu #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .in_valid_pc(in_valid_pc), .pc(pc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .out_valid_IFU(out_valid_IFU),
    .fetch_err(fetch_err), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver ----------------
  // mode 0: pulse in_valid_pc now; 1: pulse already driven by the caller;
  // 2: no pulse, the reset fetch is already in flight (current cycle = 1).
  // chain: at completion, drive the next request in that same cycle.
  // glitch: pulse a bogus in_valid_pc while the read-data phase is open.
  task automatic run_fetch(input logic [31:0] fpc, input logic [31:0] data_in,
                           input int ard, input int rd, input logic [1:0] resp,
                           input int mode, input bit chain,
                           input logic [31:0] next_pc, input bit glitch);
    logic [31:0]  data;
    logic [31:0]  exp_addr;
    logic [W-1:0] exp;
    bit mis;
    bit done;
    bit glitched;
    int exp_lat;
    int cyc;
    int ar_cnt;
    int r_cnt;
    mis      = CHK && (fpc[1:0] != 2'b00);
    data     = mis ? 32'h0 : data_in;
    exp_addr = CHK ? fpc : {fpc[31:2], 2'b00};
    exp_lat  = mis ? 1 : 3 + ard + rd;
    exp_q.push_back({(mis || (resp != 2'b00)), data, fpc});
    done = 0; glitched = 0; ar_cnt = 0; r_cnt = 0;
    if (mode == 0) begin
      @(negedge clock);
      in_valid_pc = 1'b1;
      pc = fpc;
    end
    if (mode != 2) begin
      @(negedge clock);
      in_valid_pc = 1'b0;
      pc = $urandom;
    end
    cyc = 1;
    while (!done && cyc <= BUDGET) begin
      if (out_valid_IFU) begin
        done = 1;
      end else begin
        if (glitched) in_valid_pc = 1'b0;
        if (arvalid) begin
          tests++;
          if (mis || araddr !== exp_addr)
            $display("FAIL araddr: got %h (arvalid=%b) want %h mis=%0d", araddr, arvalid, exp_addr, mis);
          arready = (ar_cnt >= ard);
          ar_cnt++;
        end else begin
          arready = 1'b0;
        end
        if (rready) begin
          rvalid = (r_cnt >= rd);
          rdata  = rvalid ? data : $urandom;
          rresp  = rvalid ? resp : 2'b00;
          r_cnt++;
          if (glitch && !glitched) begin
            in_valid_pc = 1'b1;
            pc = fpc ^ 32'h0000_0ff0;
            glitched = 1;
          end
        end else begin
          rvalid = 1'b0;
        end
        @(negedge clock);
        cyc++;
      end
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    in_valid_pc = 1'b0;
    exp = exp_q.pop_front();
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout: no out_valid_IFU within %0d cycles for pc %h", BUDGET, fpc);
    end else begin
      tests++;
      if (cyc !== exp_lat) begin fails++; $display("FAIL latency: got %0d want %0d pc %h", cyc, exp_lat, fpc); end
      tests++;
      if (inst !== exp[63:32]) begin fails++; $display("FAIL inst: got %h want %h", inst, exp[63:32]); end
      tests++;
      if (inst_pc !== exp[31:0]) begin fails++; $display("FAIL inst_pc: got %h want %h", inst_pc, exp[31:0]); end
      tests++;
      if (fetch_err !== exp[64]) begin fails++; $display("FAIL fetch_err: got %b want %b", fetch_err, exp[64]); end
      tests++;
      if (busy !== 1'b0 || state_dbg !== IFU_IDLE) begin
        fails++; $display("FAIL idle_at_valid: busy %b state %0d want busy 0 state IDLE", busy, state_dbg);
      end
      tests++;
      if (araddr !== exp_addr || arvalid !== 1'b0) begin
        fails++; $display("FAIL addr_hold: araddr %h arvalid %b want %h / 0", araddr, arvalid, exp_addr);
      end
      if (chain) begin
        in_valid_pc = 1'b1;
        pc = next_pc;
      end else begin
        @(negedge clock);
        tests++;
        if (out_valid_IFU !== 1'b0 || arvalid !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $display("FAIL single_pulse: out_valid %b arvalid %b busy %b want 0 0 0", out_valid_IFU, arvalid, busy);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if (araddr !== RST_PC || arvalid !== 1'b1 || rready !== 1'b0 || inst !== 32'h0 ||
        inst_pc !== 32'h0 || out_valid_IFU !== 1'b0 || fetch_err !== 1'b0 || busy !== 1'b1 ||
        state_dbg !== IFU_ADDR) begin
      fails++;
      $display("FAIL %s: araddr %h arvalid %b rready %b inst %h inst_pc %h ov %b err %b busy %b st %0d want %h 1 0 0 0 0 0 1 ADDR",
               tag, araddr, arvalid, rready, inst, inst_pc, out_valid_IFU, fetch_err, busy, state_dbg, RST_PC);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
    repeat (3) @(negedge clock);
    check_reset_values("reset_values");
    reset = 1'b1;
    run_fetch(RST_PC, 32'h0000_0413, 0, 0, 2'b00, 2, 0, 32'h0, 0);
  endtask

  task automatic test_stall;
    run_fetch(32'h3000_0104, $urandom, 2, 3, 2'b00, 0, 0, 32'h0, 0);
  endtask

  task automatic test_error;
    run_fetch(32'h3000_0010, $urandom, 0, 1, RESP_SLVERR, 0, 0, 32'h0, 0);
    run_fetch(32'h3000_0014, $urandom, 1, 0, RESP_OKAY,   0, 0, 32'h0, 0);
    run_fetch(32'h3000_0018, $urandom, 0, 0, RESP_DECERR, 0, 0, 32'h0, 0);
  endtask

  task automatic test_ignore_in_data;
    run_fetch(32'h3000_0200, $urandom, 1, 2, 2'b00, 0, 0, 32'h0, 1);
    run_fetch(32'h3000_0204, $urandom, 0, 0, 2'b00, 0, 0, 32'h0, 1);
  endtask

  task automatic test_back_to_back;
    run_fetch(32'h3000_0300, $urandom, 0, 0, 2'b00, 0, 1, 32'h3000_0304, 0);
    run_fetch(32'h3000_0304, $urandom, 1, 0, 2'b00, 1, 1, 32'h3000_0308, 0);
    run_fetch(32'h3000_0308, $urandom, 0, 2, 2'b00, 1, 0, 32'h0, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    in_valid_pc = 1'b1; pc = 32'h3000_0400;
    @(negedge clock);
    in_valid_pc = 1'b0;
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0; rvalid = 1'b0;
    tests++;
    if (rready !== 1'b1) begin fails++; $display("FAIL reach_data: rready %b want 1", rready); end
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clock);
    check_reset_values("reset_held");
    reset = 1'b1;
    run_fetch(RST_PC, $urandom, 1, 2, 2'b00, 2, 0, 32'h0, 0);
  endtask

  task automatic test_misalign;
    run_fetch(32'h3000_0002, $urandom, 0, 0, 2'b00, 0, 0, 32'h0, 0);
    run_fetch(32'h3000_0023, $urandom, 1, 1, 2'b00, 0, 0, 32'h0, 0);
  endtask

  task automatic test_random;
    logic [31:0] cur_pc;
    logic [31:0] nxt_pc;
    logic [1:0]  resp;
    bit chain;
    bit prev_chain;
    prev_chain = 0;
    cur_pc = 32'h3000_0000 | ($urandom & 32'h0000_fffc);
    for (int i = 0; i < 24; i++) begin
      nxt_pc = 32'h3000_0000 | ($urandom & 32'h0000_ffff);
      if ($urandom_range(0, 3) != 0) nxt_pc[1:0] = 2'b00;
      chain = (i < 23) && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        3: resp = RESP_SLVERR;
        4: resp = RESP_DECERR;
        5: resp = 2'b01;
        default: resp = RESP_OKAY;
      endcase
      run_fetch(cur_pc, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), resp,
                prev_chain ? 1 : 0, chain, nxt_pc, ($urandom_range(0, 3) == 0));
      prev_chain = chain;
      cur_pc = nxt_pc;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0; in_valid_pc = 1'b0; pc = 32'h0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    test_reset();
    test_stall();
    test_error();
    test_ignore_in_data();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    test_random();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
